// File: rtl/ysyx_25040111_rd_arbiter.sv
// ysyx_25040111_rd_arbiter: two-master read arbiter sequencing one AXI4 read port
// Requests are latched as pending, granted one at a time, and beats are returned with registered rok pulses.
module ysyx_25040111_rd_arbiter #(
    parameter bit LSU_FIRST = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ic_rstart,
    input  logic [31:0] ic_raddr,
    input  logic [7:0]  ic_rlen,
    output logic        ic_rok,
    output logic [31:0] ic_rdata,
    output logic        ic_rerr,
    input  logic        ls_rstart,
    input  logic [31:0] ls_raddr,
    input  logic [7:0]  ls_rlen,
    output logic        ls_rok,
    output logic [31:0] ls_rdata,
    output logic        ls_rerr,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    state_t      state_q;
    logic        ic_pend_q, ls_pend_q, last_ls_q, own_ls_q, over_q;
    logic [31:0] ic_addr_q, ls_addr_q, araddr_q;
    logic [7:0]  ic_len_q, ls_len_q, arlen_q, cnt_q;
    logic        ic_rok_q, ic_rerr_q, ls_rok_q, ls_rerr_q;
    logic [31:0] ic_rdata_q, ls_rdata_q;
    logic        idle, grant_ls, grant_ic, beat, beat_err, ic_beat, ls_beat;
    assign idle     = state_q == IDLE;
    // On a tie the requester not granted last wins, unless LSU priority is fixed
    assign grant_ls = ls_pend_q & (~ic_pend_q | LSU_FIRST | ~last_ls_q);
    assign grant_ic = ic_pend_q & ~grant_ls;
    assign beat     = (state_q == R) & rvalid;
    assign ic_beat  = beat & ~own_ls_q;
    assign ls_beat  = beat & own_ls_q;
    // over_q keeps flagging every beat once the burst has run past arlen without rlast
    assign beat_err = (rresp != 2'b00) | (rlast != (cnt_q == arlen_q)) | over_q;
    assign arvalid  = state_q == AR;
    assign rready   = state_q == R;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign ic_rok   = ic_rok_q;
    assign ic_rdata = ic_rdata_q;
    assign ic_rerr  = ic_rerr_q;
    assign ls_rok   = ls_rok_q;
    assign ls_rdata = ls_rdata_q;
    assign ls_rerr  = ls_rerr_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ic_pend_q  <= 1'b0;
            ls_pend_q  <= 1'b0;
            last_ls_q  <= 1'b0;
            own_ls_q   <= 1'b0;
            over_q     <= 1'b0;
            ic_addr_q  <= 32'h0;
            ls_addr_q  <= 32'h0;
            ic_len_q   <= 8'h0;
            ls_len_q   <= 8'h0;
            araddr_q   <= 32'h0;
            arlen_q    <= 8'h0;
            cnt_q      <= 8'h0;
            ic_rok_q   <= 1'b0;
            ic_rdata_q <= 32'h0;
            ic_rerr_q  <= 1'b0;
            ls_rok_q   <= 1'b0;
            ls_rdata_q <= 32'h0;
            ls_rerr_q  <= 1'b0;
        end else begin
            ic_rok_q   <= ic_beat;
            ic_rdata_q <= ic_beat ? rdata : 32'h0;
            ic_rerr_q  <= ic_beat & beat_err;
            ls_rok_q   <= ls_beat;
            ls_rdata_q <= ls_beat ? rdata : 32'h0;
            ls_rerr_q  <= ls_beat & beat_err;
            ic_pend_q  <= ic_rstart | (ic_pend_q & ~(idle & grant_ic));
            ls_pend_q  <= ls_rstart | (ls_pend_q & ~(idle & grant_ls));
            if (ic_rstart) begin
                ic_addr_q <= ic_raddr;
                ic_len_q  <= ic_rlen;
            end
            if (ls_rstart) begin
                ls_addr_q <= ls_raddr;
                ls_len_q  <= ls_rlen;
            end
            case (state_q)
                IDLE: if (grant_ic | grant_ls) begin
                    own_ls_q  <= grant_ls;
                    last_ls_q <= grant_ls;
                    araddr_q  <= grant_ls ? ls_addr_q : ic_addr_q;
                    arlen_q   <= grant_ls ? ls_len_q : ic_len_q;
                    cnt_q     <= 8'h0;
                    over_q    <= 1'b0;
                    state_q   <= AR;
                end
                AR: if (arready) state_q <= R;
                R: if (rvalid) begin
                    cnt_q  <= cnt_q + 8'd1;
                    over_q <= over_q | ((cnt_q == arlen_q) & ~rlast);
                    if (rlast) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25040111_rd_arbiter.sv
// tb_ysyx_25040111_rd_arbiter: directed scenarios plus a randomized run against a transaction-level model
module tb_ysyx_25040111_rd_arbiter;
    logic        clock = 1'b0, reset = 1'b1;
    logic        ic_rstart = 1'b0, ls_rstart = 1'b0;
    logic [31:0] ic_raddr = 32'h0, ls_raddr = 32'h0;
    logic [7:0]  ic_rlen = 8'h0, ls_rlen = 8'h0;
    logic        ic_rok, ic_rerr, ls_rok, ls_rerr;
    logic [31:0] ic_rdata, ls_rdata;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready, rlast = 1'b0;
    logic [31:0] araddr, rdata = 32'h0;
    logic [7:0]  arlen;
    logic [1:0]  rresp = 2'b00;
    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    ysyx_25040111_rd_arbiter dut (
        .clock(clock), .reset(reset),
        .ic_rstart(ic_rstart), .ic_raddr(ic_raddr), .ic_rlen(ic_rlen),
        .ic_rok(ic_rok), .ic_rdata(ic_rdata), .ic_rerr(ic_rerr),
        .ls_rstart(ls_rstart), .ls_raddr(ls_raddr), .ls_rlen(ls_rlen),
        .ls_rok(ls_rok), .ls_rdata(ls_rdata), .ls_rerr(ls_rerr),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        ic_rstart = 1'b0; ls_rstart = 1'b0; arready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_ar(output int n);
        n = 0;
        while (!arvalid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic accept_ar();
        arready = 1'b1;
        step();
        arready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rvalid = 1'b1; rdata = d; rresp = resp; rlast = last;
        step();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({arvalid, rready, araddr, arlen, ic_rok, ic_rdata, ic_rerr, ls_rok, ls_rdata, ls_rerr} !== 110'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {arvalid, rready, araddr, arlen, ic_rok, ic_rdata, ic_rerr, ls_rok, ls_rdata, ls_rerr});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({arvalid, rready} !== 2'b00) begin failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=00", i, {arvalid, rready}); end
        end
    endtask

    task automatic test_single_ic();
        int n;
        ic_rstart = 1'b1; ic_raddr = 32'h8000_0010; ic_rlen = 8'd3;
        step();
        ic_rstart = 1'b0;
        checks++;
        if (arvalid !== 1'b0) begin failures++; $display("FAIL single_early_ar got=%b exp=0", arvalid); end
        wait_ar(n);
        checks++;
        if (n != 1) begin failures++; $display("FAIL single_ar_latency got=%0d exp=1", n); end
        checks++;
        if ({araddr, arlen} !== {32'h8000_0010, 8'd3}) begin failures++; $display("FAIL single_ar got=%h/%0d exp=80000010/3", araddr, arlen); end
        accept_ar();
        checks++;
        if ({arvalid, rready} !== 2'b01) begin failures++; $display("FAIL single_rready got=%b exp=01", {arvalid, rready}); end
        for (int i = 0; i < 4; i++) begin
            beat(32'(32'hA0 + i), 2'b00, i == 3);
            checks++;
            if ({ic_rok, ic_rdata, ic_rerr, ls_rok} !== {1'b1, 32'(32'hA0 + i), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL single_beat%0d got rok=%b data=%h err=%b ls_rok=%b exp 1/%h/0/0", i, ic_rok, ic_rdata, ic_rerr, ls_rok, 32'(32'hA0 + i));
            end
        end
        checks++;
        if (rready !== 1'b0) begin failures++; $display("FAIL single_back_idle rready got=%b exp=0", rready); end
        step();
        checks++;
        if ({ic_rok, ls_rok} !== 2'b00) begin failures++; $display("FAIL single_rok_width got=%b exp=00", {ic_rok, ls_rok}); end
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        ic_rstart = 1'b1; ic_raddr = 32'h100; ic_rlen = 8'd0;
        ls_rstart = 1'b1; ls_raddr = 32'h200; ls_rlen = 8'd0;
        step();
        ic_rstart = 1'b0; ls_rstart = 1'b0;
        wait_ar(n);
        checks++;
        if (n != 1 || araddr !== 32'h200) begin failures++; $display("FAIL tie_first got=%h after %0d exp=200 after 1", araddr, n); end
        accept_ar();
        beat(32'h11, 2'b00, 1'b1);
        checks++;
        if ({ls_rok, ls_rdata, ic_rok} !== {1'b1, 32'h11, 1'b0}) begin failures++; $display("FAIL tie_ls_beat got=%b/%h/%b exp=1/11/0", ls_rok, ls_rdata, ic_rok); end
        wait_ar(n);
        checks++;
        if (n != 1 || araddr !== 32'h100) begin failures++; $display("FAIL tie_second got=%h after %0d exp=100 after 1", araddr, n); end
        accept_ar();
        beat(32'h22, 2'b00, 1'b1);
        checks++;
        if ({ic_rok, ic_rdata, ls_rok} !== {1'b1, 32'h22, 1'b0}) begin failures++; $display("FAIL tie_ic_beat got=%b/%h/%b exp=1/22/0", ic_rok, ic_rdata, ls_rok); end
    endtask

    task automatic test_during();
        int n;
        ls_rstart = 1'b1; ls_raddr = 32'h400; ls_rlen = 8'd2;
        step();
        ls_rstart = 1'b0;
        wait_ar(n);
        accept_ar();
        for (int i = 0; i < 3; i++) begin
            ic_rstart = (i == 1); ic_raddr = 32'h300; ic_rlen = 8'd1;
            beat(32'(32'h30 + i), 2'b00, i == 2);
            ic_rstart = 1'b0;
            checks++;
            if ({ls_rok, ls_rdata, ls_rerr, ic_rok} !== {1'b1, 32'(32'h30 + i), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL during_ls_beat%0d got=%b/%h/%b ic=%b exp=1/%h/0/0", i, ls_rok, ls_rdata, ls_rerr, ic_rok, 32'(32'h30 + i));
            end
        end
        wait_ar(n);
        checks++;
        if (n != 1 || {araddr, arlen} !== {32'h300, 8'd1}) begin failures++; $display("FAIL during_ic_ar got=%h/%0d after %0d exp=300/1 after 1", araddr, arlen, n); end
        accept_ar();
        for (int i = 0; i < 2; i++) begin
            beat(32'(32'h40 + i), 2'b00, i == 1);
            checks++;
            if ({ic_rok, ic_rdata, ic_rerr} !== {1'b1, 32'(32'h40 + i), 1'b0}) begin failures++; $display("FAIL during_ic_beat%0d got=%b/%h/%b", i, ic_rok, ic_rdata, ic_rerr); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        ic_rstart = 1'b1; ic_raddr = 32'h500; ic_rlen = 8'd0;
        step();
        ic_rstart = 1'b0;
        wait_ar(n);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({arvalid, rready, araddr, arlen} !== {1'b1, 1'b0, 32'h500, 8'd0}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b r=%b a=%h l=%0d exp 1/0/500/0", i, arvalid, rready, araddr, arlen);
            end
            if (i < 5) step();
        end
        accept_ar();
        checks++;
        if ({arvalid, rready} !== 2'b01) begin failures++; $display("FAIL bp_rready got=%b exp=01", {arvalid, rready}); end
        beat(32'h50, 2'b00, 1'b1);
        checks++;
        if ({ic_rok, ic_rdata} !== {1'b1, 32'h50}) begin failures++; $display("FAIL bp_beat got=%b/%h exp=1/50", ic_rok, ic_rdata); end
    endtask

    task automatic test_errors();
        int n;
        ls_rstart = 1'b1; ls_raddr = 32'h600; ls_rlen = 8'd3;
        step();
        ls_rstart = 1'b0;
        wait_ar(n);
        accept_ar();
        for (int i = 0; i < 4; i++) begin
            beat(32'(32'h60 + i), (i == 1) ? 2'd2 : 2'd0, i == 3);
            checks++;
            if ({ls_rok, ls_rerr} !== {1'b1, 1'(i == 1)}) begin failures++; $display("FAIL err_resp beat%0d got rok=%b err=%b exp 1/%b", i, ls_rok, ls_rerr, i == 1); end
        end
        ic_rstart = 1'b1; ic_raddr = 32'h700; ic_rlen = 8'd3;
        step();
        ic_rstart = 1'b0;
        wait_ar(n);
        accept_ar();
        for (int i = 0; i < 2; i++) begin
            beat(32'(32'h70 + i), 2'b00, i == 1);
            checks++;
            if ({ic_rok, ic_rerr} !== {1'b1, 1'(i == 1)}) begin failures++; $display("FAIL err_early_last beat%0d got rok=%b err=%b exp 1/%b", i, ic_rok, ic_rerr, i == 1); end
        end
        checks++;
        if (rready !== 1'b0) begin failures++; $display("FAIL err_early_idle rready got=%b exp=0", rready); end
        ic_rstart = 1'b1; ic_raddr = 32'h780; ic_rlen = 8'd0;
        step();
        ic_rstart = 1'b0;
        wait_ar(n);
        accept_ar();
        for (int i = 0; i < 3; i++) begin
            beat(32'(i), 2'b00, i == 2);
            checks++;
            if ({ic_rok, ic_rerr} !== 2'b11) begin failures++; $display("FAIL err_missing_last beat%0d got rok=%b err=%b exp 1/1", i, ic_rok, ic_rerr); end
        end
    endtask

    task automatic test_wrap();
        int n;
        ls_rstart = 1'b1; ls_raddr = 32'hA00; ls_rlen = 8'd255;
        step();
        ls_rstart = 1'b0;
        wait_ar(n);
        checks++;
        if (arlen !== 8'd255) begin failures++; $display("FAIL wrap_arlen got=%0d exp=255", arlen); end
        accept_ar();
        for (int i = 0; i < 256; i++) begin
            beat(32'(i), 2'b00, i == 255);
            checks++;
            if ({ls_rok, ls_rdata, ls_rerr} !== {1'b1, 32'(i), 1'b0}) begin failures++; $display("FAIL wrap_beat%0d got=%b/%h/%b exp=1/%h/0", i, ls_rok, ls_rdata, ls_rerr, 32'(i)); end
        end
        checks++;
        if (rready !== 1'b0) begin failures++; $display("FAIL wrap_idle rready got=%b exp=0", rready); end
    endtask

    task automatic test_reset_mid();
        int n;
        ic_rstart = 1'b1; ic_raddr = 32'h800; ic_rlen = 8'd3;
        step();
        ic_rstart = 1'b0;
        wait_ar(n);
        accept_ar();
        beat(32'h80, 2'b00, 1'b0);
        ic_rstart = 1'b1; ic_raddr = 32'h880; ic_rlen = 8'd0;
        beat(32'h81, 2'b00, 1'b0);
        ic_rstart = 1'b0;
        checks++;
        if ({ic_rok, ic_rdata} !== {1'b1, 32'h81}) begin failures++; $display("FAIL rmid_beat got=%b/%h exp=1/81", ic_rok, ic_rdata); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({arvalid, rready, araddr, arlen, ic_rok, ic_rdata, ic_rerr, ls_rok, ls_rdata, ls_rerr} !== 110'd0) begin
            failures++;
            $display("FAIL rmid_outputs got=%h exp=0", {arvalid, rready, araddr, arlen, ic_rok, ic_rdata, ic_rerr, ls_rok, ls_rdata, ls_rerr});
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({arvalid, rready} !== 2'b00) begin failures++; $display("FAIL rmid_no_ar cyc=%0d got=%b exp=00", i, {arvalid, rready}); end
        end
        ls_rstart = 1'b1; ls_raddr = 32'h900; ls_rlen = 8'd0;
        step();
        ls_rstart = 1'b0;
        wait_ar(n);
        checks++;
        if (n != 1 || araddr !== 32'h900) begin failures++; $display("FAIL rmid_new_ar got=%h after %0d exp=900 after 1", araddr, n); end
        accept_ar();
        beat(32'h90, 2'b00, 1'b1);
        checks++;
        if ({ls_rok, ls_rdata, ls_rerr} !== {1'b1, 32'h90, 1'b0}) begin failures++; $display("FAIL rmid_new_beat got=%b/%h/%b", ls_rok, ls_rdata, ls_rerr); end
    endtask

    // Transaction-level model: pending slots per requester, one bus burst at a time
    task automatic test_random();
        bit          m_pend[2];
        logic [31:0] m_addr[2];
        logic [7:0]  m_len[2];
        bit          e_rok[2], e_err[2];
        logic [31:0] e_data[2];
        logic [31:0] cur_a;
        logic [7:0]  cur_l;
        int          m_last, phase, idx, cur_who, g;
        do_reset();
        m_pend = '{0, 0}; e_rok = '{0, 0}; e_err = '{0, 0};
        m_addr = '{32'h0, 32'h0}; m_len = '{8'h0, 8'h0}; e_data = '{32'h0, 32'h0};
        m_last = 0; phase = 0; idx = 0; cur_who = 0; cur_a = 32'h0; cur_l = 8'h0;
        for (int c = 0; c < 1500; c++) begin
            checks++;
            if ({ic_rok, ls_rok} !== {e_rok[0], e_rok[1]}) begin failures++; $display("FAIL rand_rok cyc=%0d got=%b exp=%b", c, {ic_rok, ls_rok}, {e_rok[0], e_rok[1]}); end
            if (e_rok[0]) begin
                checks++;
                if ({ic_rdata, ic_rerr} !== {e_data[0], e_err[0]}) begin failures++; $display("FAIL rand_ic_data cyc=%0d got=%h/%b exp=%h/%b", c, ic_rdata, ic_rerr, e_data[0], e_err[0]); end
            end
            if (e_rok[1]) begin
                checks++;
                if ({ls_rdata, ls_rerr} !== {e_data[1], e_err[1]}) begin failures++; $display("FAIL rand_ls_data cyc=%0d got=%h/%b exp=%h/%b", c, ls_rdata, ls_rerr, e_data[1], e_err[1]); end
            end
            checks++;
            if ({arvalid, rready} !== {1'(phase == 1), 1'(phase == 2)}) begin failures++; $display("FAIL rand_phase cyc=%0d got=%b exp phase=%0d", c, {arvalid, rready}, phase); end
            if (phase == 1) begin
                checks++;
                if ({araddr, arlen} !== {cur_a, cur_l}) begin failures++; $display("FAIL rand_ar cyc=%0d got=%h/%0d exp=%h/%0d", c, araddr, arlen, cur_a, cur_l); end
            end
            ic_rstart = ($urandom_range(0, 5) == 0); ic_raddr = $urandom; ic_rlen = 8'($urandom_range(0, 3));
            ls_rstart = ($urandom_range(0, 5) == 0); ls_raddr = $urandom; ls_rlen = 8'($urandom_range(0, 3));
            arready = ($urandom_range(0, 2) != 0);
            rvalid = ($urandom_range(0, 3) != 0);
            rdata = $urandom;
            rresp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rlast = (idx >= int'(cur_l)) ^ ($urandom_range(0, 15) == 0);
            e_rok = '{0, 0};
            if (phase == 2 && rvalid) begin
                e_rok[cur_who] = 1'b1;
                e_data[cur_who] = rdata;
                e_err[cur_who] = (rresp != 2'b00) || (rlast != (idx == int'(cur_l))) || (idx > int'(cur_l));
                idx++;
                if (rlast) phase = 0;
            end else if (phase == 1 && arready) begin
                phase = 2;
                idx = 0;
            end else if (phase == 0 && (m_pend[0] || m_pend[1])) begin
                g = (m_pend[1] && (!m_pend[0] || m_last == 0)) ? 1 : 0;
                cur_who = g; cur_a = m_addr[g]; cur_l = m_len[g];
                m_pend[g] = 1'b0; m_last = g; phase = 1;
            end
            if (ic_rstart) begin m_pend[0] = 1'b1; m_addr[0] = ic_raddr; m_len[0] = ic_rlen; end
            if (ls_rstart) begin m_pend[1] = 1'b1; m_addr[1] = ls_raddr; m_len[1] = ls_rlen; end
            step();
        end
        clear_in();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_ic();
        test_tie();
        test_during();
        test_backpressure();
        test_errors();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
